// File: rtl/mio_port_arb_pkg.sv
// Shared types and defaults for the CPU / memory-io single-port arbiter.
package mio_port_arb_pkg;

    localparam int MEM_ADDR_W   = 24;
    localparam int WAIT_MAX_DEF = 64;
    localparam int ACK_TMO_DEF  = 255;

    typedef enum logic [1:0] {
        IDLE,
        CPU_ACC,
        CPU_DONE,
        MIO_ACC
    } arb_state_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [15:0]           dati;
        logic                  we_hi;
        logic                  we_lo;
    } mem_req_t;

    function automatic logic is_read(mem_req_t r);
        return !(r.we_hi || r.we_lo);
    endfunction

endpackage

// File: rtl/mio_port_arb_if.sv
// Request/acknowledge link between the arbiter and the memory controller.
interface mio_port_arb_if #(
    parameter int ADDR_W = mio_port_arb_pkg::MEM_ADDR_W
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we_hi;
    logic              mem_we_lo;
    logic [15:0]       mem_dati;
    logic              mem_ack;
    logic [15:0]       mem_dato;

    modport master (
        output mem_req, mem_addr, mem_we_hi, mem_we_lo, mem_dati,
        input  mem_ack, mem_dato
    );

    modport slave (
        input  mem_req, mem_addr, mem_we_hi, mem_we_lo, mem_dati,
        output mem_ack, mem_dato
    );
endinterface

// File: rtl/mio_req_latch.sv
// Captures one memory-io request on a strobe rising edge and holds it until served.
module mio_req_latch
    import mio_port_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              mio_oe,
    input  logic              mio_we_hi,
    input  logic              mio_we_lo,
    input  logic [ADDR_W-1:0] mio_addr,
    input  logic [15:0]       mio_dati,
    input  logic              done,
    output logic              pending,
    output mem_req_t          req,
    output logic              err_ovf
);
    logic s, s_q, rise, busy;

    assign s    = mio_oe | mio_we_hi | mio_we_lo;
    assign rise = s & ~s_q;
    // A request finishing this cycle frees the slot for a same-cycle strobe.
    assign busy = pending & ~done;

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            s_q     <= 1'b0;
            pending <= 1'b0;
            req     <= '0;
            err_ovf <= 1'b0;
        end else begin
            s_q <= s;
            if (rise && !busy) begin
                pending <= 1'b1;
                req     <= '{addr: MEM_ADDR_W'(mio_addr), dati: mio_dati,
                             we_hi: mio_we_hi, we_lo: mio_we_lo};
            end else if (done) begin
                pending <= 1'b0;
            end
            if (rise && busy)
                err_ovf <= 1'b1;
        end
    end
endmodule

// File: rtl/mio_port_arb.sv
// CPU-priority arbiter serializing CPU and memory-io accesses onto one memory port,
// with a starvation limit for memory-io and an ack timeout.
module mio_port_arb
    import mio_port_arb_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int ACK_TMO  = ACK_TMO_DEF
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we_hi,
    input  logic              cpu_we_lo,
    input  logic [15:0]       cpu_dati,
    output logic [15:0]       cpu_dato,
    input  logic              mio_oe,
    input  logic              mio_we_hi,
    input  logic              mio_we_lo,
    input  logic [ADDR_W-1:0] mio_addr,
    input  logic [15:0]       mio_dati,
    output logic [15:0]       mio_dato,
    output logic              mio_busy,
    output logic              err_tmo,
    output logic              err_ovf,
    mio_port_arb_if.master    mem
);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam int TMO_W  = $clog2(ACK_TMO + 1);

    arb_state_t        state, state_nxt;
    mem_req_t          mio_rq, cpu_rq, cur;
    logic              pending, req_q, acc, ack, tmo, fin, starve, mio_done;
    logic [WAIT_W-1:0] wait_cnt;
    logic [TMO_W-1:0]  tmo_cnt;

    mio_req_latch #(.ADDR_W(ADDR_W)) u_latch (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .mio_oe   (mio_oe),
        .mio_we_hi(mio_we_hi),
        .mio_we_lo(mio_we_lo),
        .mio_addr (mio_addr),
        .mio_dati (mio_dati),
        .done     (mio_done),
        .pending  (pending),
        .req      (mio_rq),
        .err_ovf  (err_ovf)
    );

    assign cpu_rq   = '{addr: MEM_ADDR_W'(cpu_addr), dati: cpu_dati,
                        we_hi: cpu_we_hi, we_lo: cpu_we_lo};
    assign acc      = (state == CPU_ACC) || (state == MIO_ACC);
    assign ack      = req_q & mem.mem_ack;
    // Abort after ACK_TMO request cycles; an ack in that same cycle still wins.
    assign tmo      = acc & ~ack & (tmo_cnt == TMO_W'(ACK_TMO - 1));
    assign fin      = acc & (ack | tmo);
    assign mio_done = (state == MIO_ACC) & fin;
    assign starve   = pending & (wait_cnt >= WAIT_W'(WAIT_MAX));

    assign mem.mem_req   = req_q;
    assign mem.mem_addr  = ADDR_W'(cur.addr);
    assign mem.mem_we_hi = cur.we_hi;
    assign mem.mem_we_lo = cur.we_lo;
    assign mem.mem_dati  = cur.dati;
    assign mio_busy      = pending;

    always_ff @(posedge clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (starve)       state_nxt = MIO_ACC;
                else if (cpu_req) state_nxt = CPU_ACC;
                else if (pending) state_nxt = MIO_ACC;
            end
            CPU_ACC:  if (fin)      state_nxt = CPU_DONE;
            CPU_DONE: if (!cpu_req) state_nxt = IDLE;
            MIO_ACC:  if (fin)      state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            req_q    <= 1'b0;
            cur      <= '0;
            cpu_dato <= 16'hFFFF;
            mio_dato <= 16'hFFFF;
            err_tmo  <= 1'b0;
            wait_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            if (state == IDLE && state_nxt != IDLE) begin
                req_q <= 1'b1;
                cur   <= (state_nxt == CPU_ACC) ? cpu_rq : mio_rq;
            end
            if (fin) begin
                req_q <= 1'b0;
                if (is_read(cur)) begin
                    if (state == CPU_ACC) cpu_dato <= tmo ? 16'hFFFF : mem.mem_dato;
                    else                  mio_dato <= tmo ? 16'hFFFF : mem.mem_dato;
                end
                if (tmo)
                    err_tmo <= 1'b1;
            end
            tmo_cnt <= (acc && !fin) ? tmo_cnt + TMO_W'(1) : '0;
            if (state == IDLE && state_nxt == MIO_ACC)
                wait_cnt <= '0;
            else if (pending && state != MIO_ACC && wait_cnt < WAIT_W'(WAIT_MAX))
                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end
endmodule

// File: tb/tb_mio_port_arb.sv
// Directed bench for mio_port_arb: a memory-controller model plus a scoreboard of expected accesses.
module tb_mio_port_arb;
    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we_hi = 1'b0, cpu_we_lo = 1'b0;
    logic [23:0] cpu_addr = '0, mio_addr = '0;
    logic [15:0] cpu_dati = '0, mio_dati = '0;
    logic        mio_oe = 1'b0, mio_we_hi = 1'b0, mio_we_lo = 1'b0;
    logic [15:0] cpu_dato, mio_dato;
    logic        mio_busy, err_tmo, err_ovf;

    always #5 clk = ~clk;

    mio_port_arb_if #(.ADDR_W(24)) mem_if ();

    mio_port_arb #(.ADDR_W(24), .WAIT_MAX(4), .ACK_TMO(255)) dut (
        .clk(clk), .sys_rst(sys_rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we_hi(cpu_we_hi), .cpu_we_lo(cpu_we_lo),
        .cpu_dati(cpu_dati), .cpu_dato(cpu_dato),
        .mio_oe(mio_oe), .mio_we_hi(mio_we_hi), .mio_we_lo(mio_we_lo),
        .mio_addr(mio_addr), .mio_dati(mio_dati), .mio_dato(mio_dato),
        .mio_busy(mio_busy), .err_tmo(err_tmo), .err_ovf(err_ovf),
        .mem(mem_if)
    );

    typedef struct {
        logic [23:0] addr;
        logic        hi;
        logic        lo;
        logic [15:0] d;
    } exp_t;

    exp_t expq[$];
    int   checks = 0, errors = 0;
    int   issued = 0, req_cycles = 0, base = 0;
    int   ack_dly = 1, mcnt = 0;
    logic [15:0] rd_data = '0;
    logic spur = 1'b0, req_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_acc(input logic [23:0] a, input logic hi, input logic lo, input logic [15:0] d);
        exp_t e;
        e.addr = a; e.hi = hi; e.lo = lo; e.d = d;
        expq.push_back(e);
    endtask

    // Memory controller: acks ack_dly cycles into a request (0 = never).
    always @(negedge clk) begin
        mem_if.mem_ack  = spur;
        mem_if.mem_dato = rd_data;
        if (mem_if.mem_req) begin
            mcnt++;
            if (mcnt == ack_dly) mem_if.mem_ack = 1'b1;
        end else begin
            mcnt = 0;
        end
    end

    // Scoreboard monitor: every new request is matched against the next expected access.
    always @(negedge clk) begin
        exp_t e;
        if (mem_if.mem_req && !req_prev) begin
            issued++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got addr %h expected no access", mem_if.mem_addr);
            end else begin
                e = expq.pop_front();
                chk("req_addr", 32'(mem_if.mem_addr), 32'(e.addr));
                chk("req_we", {30'd0, mem_if.mem_we_hi, mem_if.mem_we_lo}, {30'd0, e.hi, e.lo});
                chk("req_dati", 32'(mem_if.mem_dati), 32'(e.d));
            end
        end
        if (mem_if.mem_req) req_cycles++;
        req_prev = mem_if.mem_req;
    end

    initial begin
        step(3);
        chk("rst_cpu_dato", 32'(cpu_dato), 32'hFFFF);
        chk("rst_mio_dato", 32'(mio_dato), 32'hFFFF);
        chk("rst_mem_req", 32'(mem_if.mem_req), 0);
        chk("rst_mem_addr", 32'(mem_if.mem_addr), 0);
        chk("rst_mem_we_dati", {14'd0, mem_if.mem_we_hi, mem_if.mem_we_lo, mem_if.mem_dati}, 0);
        chk("rst_flags", {29'd0, mio_busy, err_tmo, err_ovf}, 0);
        sys_rst = 1'b0;
        step(2);

        // CPU read held for 20 cycles: one access, three request cycles.
        ack_dly = 3; rd_data = 16'hBEEF; req_cycles = 0; base = issued;
        cpu_addr = 24'h000100; cpu_req = 1'b1;
        expect_acc(24'h000100, 1'b0, 1'b0, 16'h0000);
        step(20);
        chk("t1_req_cycles", 32'(req_cycles), 3);
        chk("t1_single_access", 32'(issued - base), 1);
        chk("t1_cpu_dato", 32'(cpu_dato), 32'hBEEF);
        cpu_req = 1'b0;
        step(3);

        // Memory-io low-byte write with the CPU idle.
        ack_dly = 2;
        mio_addr = 24'h000201; mio_dati = 16'h5A5A; mio_we_lo = 1'b1;
        expect_acc(24'h000201, 1'b0, 1'b1, 16'h5A5A);
        step(1);
        chk("t2_req_not_yet", 32'(mem_if.mem_req), 0);
        chk("t2_busy_set", 32'(mio_busy), 1);
        mio_we_lo = 1'b0;
        step(1);
        chk("t2_req_issued", 32'(mem_if.mem_req), 1);
        chk("t2_we", {30'd0, mem_if.mem_we_hi, mem_if.mem_we_lo}, 32'b01);
        step(1);
        chk("t2_busy_in_service", 32'(mio_busy), 1);
        step(1);
        chk("t2_busy_clear", 32'(mio_busy), 0);
        chk("t2_req_drop", 32'(mem_if.mem_req), 0);
        chk("t2_mio_dato_kept", 32'(mio_dato), 32'hFFFF);

        // Ack while no request is outstanding must be ignored.
        rd_data = 16'hDEAD; spur = 1'b1;
        step(2);
        spur = 1'b0;
        step(2);
        chk("spur_cpu_dato", 32'(cpu_dato), 32'hBEEF);
        chk("spur_mio_dato", 32'(mio_dato), 32'hFFFF);
        chk("spur_no_req", 32'(mem_if.mem_req), 0);

        // Back-to-back CPU bus cycles; memory-io read gets in once it has waited 4 cycles.
        ack_dly = 2; rd_data = 16'h1234; mio_dati = 16'h0000;
        expect_acc(24'h000300, 1'b0, 1'b0, 16'h0000);
        expect_acc(24'h000302, 1'b0, 1'b0, 16'h0000);
        expect_acc(24'h000400, 1'b0, 1'b0, 16'h0000);
        expect_acc(24'h000304, 1'b0, 1'b0, 16'h0000);
        cpu_addr = 24'h000300; cpu_req = 1'b1; mio_addr = 24'h000400; mio_oe = 1'b1;
        step(1);
        mio_oe = 1'b0;
        step(2);
        cpu_req = 1'b0;
        step(1);
        cpu_addr = 24'h000302; cpu_req = 1'b1;
        step(3);
        cpu_req = 1'b0;
        step(1);
        cpu_addr = 24'h000304; cpu_req = 1'b1;
        step(4);
        chk("t3_mio_served", 32'(mio_busy), 0);
        chk("t3_mio_dato", 32'(mio_dato), 32'h1234);
        step(3);
        cpu_req = 1'b0;
        step(2);
        chk("t3_cpu_dato", 32'(cpu_dato), 32'h1234);
        chk("t3_queue_drained", 32'(expq.size()), 0);

        // Memory-io read never acked: aborted after 255 request cycles.
        chk("t4_tmo_before", 32'(err_tmo), 0);
        ack_dly = 0; req_cycles = 0;
        mio_addr = 24'h000500; mio_oe = 1'b1;
        expect_acc(24'h000500, 1'b0, 1'b0, 16'h0000);
        step(1);
        mio_oe = 1'b0;
        step(262);
        chk("t4_req_cycles", 32'(req_cycles), 255);
        chk("t4_req_drop", 32'(mem_if.mem_req), 0);
        chk("t4_err_tmo", 32'(err_tmo), 1);
        chk("t4_mio_dato", 32'(mio_dato), 32'hFFFF);
        chk("t4_busy_clear", 32'(mio_busy), 0);

        // Second strobe while the first is pending behind a CPU write.
        chk("t5_ovf_before", 32'(err_ovf), 0);
        ack_dly = 1; base = issued;
        expect_acc(24'h000310, 1'b1, 1'b1, 16'h7777);
        expect_acc(24'h000600, 1'b1, 1'b0, 16'hA5A5);
        cpu_addr = 24'h000310; cpu_we_hi = 1'b1; cpu_we_lo = 1'b1; cpu_dati = 16'h7777; cpu_req = 1'b1;
        step(1);
        mio_addr = 24'h000600; mio_dati = 16'hA5A5; mio_we_hi = 1'b1;
        step(1);
        mio_we_hi = 1'b0;
        step(1);
        mio_addr = 24'h000700; mio_dati = 16'h1111; mio_we_hi = 1'b1;
        step(1);
        mio_we_hi = 1'b0;
        step(1);
        chk("t5_err_ovf", 32'(err_ovf), 1);
        chk("t5_busy", 32'(mio_busy), 1);
        cpu_req = 1'b0; cpu_we_hi = 1'b0; cpu_we_lo = 1'b0; cpu_dati = 16'h0000;
        step(5);
        chk("t5_busy_clear", 32'(mio_busy), 0);
        chk("t5_access_count", 32'(issued - base), 2);
        chk("t5_cpu_dato_kept", 32'(cpu_dato), 32'h1234);
        chk("t5_queue_drained", 32'(expq.size()), 0);

        // Reset in the middle of an unacked CPU access with a memory-io request pending.
        ack_dly = 0; mio_dati = 16'h0000;
        expect_acc(24'h000800, 1'b0, 1'b0, 16'h0000);
        cpu_addr = 24'h000800; cpu_req = 1'b1;
        step(1);
        mio_addr = 24'h000900; mio_oe = 1'b1;
        step(1);
        mio_oe = 1'b0;
        step(1);
        chk("t6_in_access", 32'(mem_if.mem_req), 1);
        chk("t6_busy", 32'(mio_busy), 1);
        sys_rst = 1'b1; cpu_req = 1'b0;
        step(1);
        chk("t6_req_drop", 32'(mem_if.mem_req), 0);
        chk("t6_mem_addr", 32'(mem_if.mem_addr), 0);
        chk("t6_cpu_dato", 32'(cpu_dato), 32'hFFFF);
        chk("t6_mio_dato", 32'(mio_dato), 32'hFFFF);
        chk("t6_flags", {29'd0, mio_busy, err_tmo, err_ovf}, 0);
        sys_rst = 1'b0; base = issued;
        step(6);
        chk("t6_pending_dropped", 32'(issued - base), 0);
        chk("t6_queue_drained", 32'(expq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
